// File: rtl/ym_float_rx_fifo_pkg.sv
// Shared types and helpers for the YM3012 float-DAC receiver: slot decode, gray coding, read FSM states.
// Functions take field geometry as arguments so each instance can use its own parameters.
package ym_rx_pkg;

  localparam int YM_NUM_CH   = 2;
  localparam int YM_OUT_BITS = 16;
  localparam int FRAME_W     = YM_NUM_CH * YM_OUT_BITS;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } rd_state_e;

  // Result is 32 bits wide; callers truncate to OUT_BITS.
  function automatic logic [31:0] ym_fp_decode(input logic [31:0] slot, input int mant_lsb,
                                               input int mant_bits, input int exp_bits);
    logic [31:0] m;
    logic [31:0] e;
    logic [31:0] v;
    m = (slot >> mant_lsb) & ((32'd1 << mant_bits) - 32'd1);
    e = (slot >> (mant_lsb + mant_bits)) & ((32'd1 << exp_bits) - 32'd1);
    v = m - (32'd1 << (mant_bits - 1));
    return (e == 32'd0) ? 32'd0 : (v << (e - 32'd1));
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/ym_float_rx_fifo_async_fifo.sv
// Dual-clock frame FIFO with gray pointers and 2-FF synchronisers; full/empty are conservative.
// Read data is combinational from the head entry; rlevel is the registered read-side fill level.
module ym_rx_async_fifo
  import ym_rx_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     wclk,
  input  logic                     rclk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   rlevel
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wbin_q, wbin_d, wgray_q, wgray_d, rsync1_q, rsync2_q;
  logic [PW-1:0]    rbin_q, rbin_d, rgray_q, rgray_d, wsync1_q, wsync2_q;
  logic [PW-1:0]    rlevel_q, rlevel_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    full     = (wgray_q == {~rsync2_q[PW-1:PW-2], rsync2_q[PW-3:0]});
    wbin_d   = wbin_q + PW'(wr_en & ~full);
    wgray_d  = PW'(bin2gray(32'(wbin_d)));
    empty    = (rgray_q == wsync2_q);
    rbin_d   = rbin_q + PW'(rd_en & ~empty);
    rgray_d  = PW'(bin2gray(32'(rbin_d)));
    rlevel_d = PW'(gray2bin(32'(wsync2_q))) - rbin_q;
  end

  always_ff @(posedge wclk or negedge reset_n) begin
    if (!reset_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      rsync1_q <= '0;
      rsync2_q <= '0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      rsync1_q <= rgray_q;
      rsync2_q <= rsync1_q;
    end
  end

  always_ff @(posedge wclk) begin
    if (wr_en && !full) mem_q[wbin_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge rclk or negedge reset_n) begin
    if (!reset_n) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      wsync1_q <= '0;
      wsync2_q <= '0;
      rlevel_q <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      wsync1_q <= wgray_q;
      wsync2_q <= wsync1_q;
      rlevel_q <= rlevel_d;
    end
  end

  assign rdata  = mem_q[rbin_q[AW-1:0]];
  assign rlevel = rlevel_q;

endmodule

// File: rtl/ym_float_rx_fifo.sv
// YM3012 serial float-DAC receiver: BCK-side shifter/decoder, async frame FIFO, AMCLK-side tick/prime FSM.
// Optional YM_RX_STATUS_EN adds saturating overflow/underrun counters.
module ym_float_rx_fifo
  import ym_rx_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int SLOT_BITS    = 16,
  parameter int MANT_LSB     = 3,
  parameter int MANT_BITS    = 10,
  parameter int EXP_BITS     = 3,
  parameter int OUT_BITS     = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int MCLK_DIVIDER = 16
) (
  input  logic                           AMCLK_i,
  input  logic                           reset_n,
  input  logic                           I2S_BCK,
  input  logic                           I2S_WS,
  input  logic                           I2S_DATA,
  output logic [NUM_CH*OUT_BITS-1:0]     APDATA_o,
  output logic                           APDATA_VALID_o,
  output logic [$clog2(FIFO_DEPTH):0]    FIFO_LEVEL_o,
  output logic                           UNDERRUN_o
`ifdef YM_RX_STATUS_EN
  ,
  output logic [7:0]                     OVF_CNT_o,
  output logic [7:0]                     UNF_CNT_o
`endif
);
  localparam int FW  = NUM_CH * OUT_BITS;
  localparam int TOT = NUM_CH * SLOT_BITS;
  localparam int CW  = $clog2(TOT);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int DW  = $clog2(MCLK_DIVIDER);

  logic           ws_prev_q, ws_prev_d, active_q, active_d, frame_done, wr_en, full;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TOT-1:0] shreg_q, shreg_d;
  logic [FW-1:0]  wdata, rdata, apdata_q, apdata_d;
  logic [DW-1:0]  div_q, div_d;
  logic [LW-1:0]  level;
  logic           empty, rd_en, vld_q, vld_d, unf_q, unf_d;
  rd_state_e      state_q, state_d;

  // Bits enter at the MSB, so after a full frame slot 0 bit 0 sits at the LSB.
  always_comb begin
    ws_prev_d  = I2S_WS;
    shreg_d    = {I2S_DATA, shreg_q[TOT-1:1]};
    active_d   = active_q;
    bit_cnt_d  = bit_cnt_q;
    frame_done = 1'b0;
    if (ws_prev_q && !I2S_WS) begin
      active_d  = 1'b1;
      bit_cnt_d = CW'(1);
    end else if (active_q) begin
      if (bit_cnt_q == CW'(TOT - 1)) begin
        frame_done = 1'b1;
        active_d   = 1'b0;
        bit_cnt_d  = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    wdata = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      wdata[ch*OUT_BITS +: OUT_BITS] = OUT_BITS'(ym_fp_decode(
          32'(shreg_d[ch*SLOT_BITS +: SLOT_BITS]), MANT_LSB, MANT_BITS, EXP_BITS));
    wr_en = frame_done & ~full;
  end

  always_ff @(posedge I2S_BCK or negedge reset_n) begin
    if (!reset_n) begin
      ws_prev_q <= 1'b0;
      active_q  <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      ws_prev_q <= ws_prev_d;
      active_q  <= active_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  ym_rx_async_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .wclk    (I2S_BCK),
    .rclk    (AMCLK_i),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .full    (full),
    .rd_en   (rd_en),
    .rdata   (rdata),
    .empty   (empty),
    .rlevel  (level)
  );

  // PRIME never pops; the tick that sees half-full only arms RUN.
  always_comb begin
    div_d    = div_q + DW'(1);
    state_d  = state_q;
    apdata_d = apdata_q;
    vld_d    = 1'b0;
    unf_d    = 1'b0;
    rd_en    = 1'b0;
    if (div_q == '0) begin
      vld_d = 1'b1;
      case (state_q)
        ST_PRIME: if (level >= LW'(FIFO_DEPTH / 2)) state_d = ST_RUN;
        ST_RUN: begin
          if (!empty) begin
            rd_en    = 1'b1;
            apdata_d = rdata;
          end else begin
            unf_d   = 1'b1;
            state_d = ST_PRIME;
          end
        end
        default: state_d = ST_PRIME;
      endcase
    end
  end

  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      state_q  <= ST_PRIME;
      apdata_q <= '0;
      vld_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      state_q  <= state_d;
      apdata_q <= apdata_d;
      vld_q    <= vld_d;
      unf_q    <= unf_d;
    end
  end

  assign APDATA_o       = apdata_q;
  assign APDATA_VALID_o = vld_q;
  assign UNDERRUN_o     = unf_q;
  assign FIFO_LEVEL_o   = level;

`ifdef YM_RX_STATUS_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d, ovf_gray_q, ovf_gray_d, ovf_s1_q, ovf_s2_q;
  logic [7:0] unf_cnt_q, unf_cnt_d;

  // Gray-coded so the saturating count crosses into AMCLK one bit-change at a time.
  always_comb begin
    ovf_cnt_d  = (frame_done && full && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;
    ovf_gray_d = 8'(bin2gray(32'(ovf_cnt_d)));
    unf_cnt_d  = (unf_d && unf_cnt_q != 8'hFF) ? unf_cnt_q + 8'd1 : unf_cnt_q;
  end

  always_ff @(posedge I2S_BCK or negedge reset_n) begin
    if (!reset_n) begin
      ovf_cnt_q  <= '0;
      ovf_gray_q <= '0;
    end else begin
      ovf_cnt_q  <= ovf_cnt_d;
      ovf_gray_q <= ovf_gray_d;
    end
  end

  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      ovf_s1_q  <= '0;
      ovf_s2_q  <= '0;
      unf_cnt_q <= '0;
    end else begin
      ovf_s1_q  <= ovf_gray_q;
      ovf_s2_q  <= ovf_s1_q;
      unf_cnt_q <= unf_cnt_d;
    end
  end

  assign OVF_CNT_o = 8'(gray2bin(32'(ovf_s2_q)));
  assign UNF_CNT_o = unf_cnt_q;
`endif

endmodule
